// File: rtl/qs_pkg.sv
// qs_pkg: shared widths and types for the qs sort engine and its receive checker
//   W  : data word width
//   N  : maximum legal packet length in beats
//   LW : width of a saturating beat count (0..N+1)
package qs_pkg;
    localparam int W  = 8;
    localparam int N  = 8;
    localparam int LW = $clog2(N + 2);

    typedef enum logic {IDLE, PKT} qs_rcv_state_t;

    typedef struct packed {
        logic [LW-1:0] len;
        logic [W-1:0]  min;
        logic [W-1:0]  max;
        logic          ord;
        logic          frm;
        logic          eng;
    } qs_rcv_stat_t;
endpackage

// File: rtl/qs_rcv_fifo.sv
// qs_rcv_fifo: flopped FIFO of status records with the head presented from storage
//   i_push/i_din : write request and record (ignored when full unless popping)
//   i_pop        : consume the head (ignored when empty)
//   o_full/o_empty, o_head : occupancy flags and current head record
module qs_rcv_fifo
    import qs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  qs_rcv_stat_t i_din,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output qs_rcv_stat_t o_head
);
    localparam int AW = $clog2(DEPTH);

    qs_rcv_stat_t r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_do_push;
    logic         w_do_pop;

    // Extra pointer MSB is a wrap bit: equal index with differing wrap means full.
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_empty   = (r_wr == r_rd);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the head slot in the same edge, so a full FIFO can still accept.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr[AW-1:0]] <= i_din;
                r_wr                <= r_wr + 1'b1;
            end
            if (w_do_pop) r_rd <= r_rd + 1'b1;
        end
    end
endmodule

// File: rtl/qs_rcv.sv
// qs_rcv: receive-side framing/order checker queuing one status record per packet
//   in_*            : beat stream from the sort engine, no backpressure
//   stat_rdy        : consumer accepts the status head
//   stat_*_r        : status FIFO head {len, min, max, ord/frm/eng errors}
//   stray_r         : one-cycle pulse, non-sop beat seen while idle was dropped
//   ovf_r           : sticky, a status record was lost
//   busy_r          : a packet is open
module qs_rcv #(
    parameter int  W          = qs_pkg::W,
    parameter int  N          = qs_pkg::N,
    parameter int  STAT_DEPTH = 4,
    localparam int LW         = $clog2(N + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic          in_sop,
    input  logic          in_eop,
    input  logic          in_err,
    input  logic [W-1:0]  in_dat,
    input  logic          stat_rdy,
    output logic          stat_vld_r,
    output logic [LW-1:0] stat_len_r,
    output logic [W-1:0]  stat_min_r,
    output logic [W-1:0]  stat_max_r,
    output logic          stat_ord_err_r,
    output logic          stat_frm_err_r,
    output logic          stat_eng_err_r,
    output logic          stray_r,
    output logic          ovf_r,
    output logic          busy_r
);
    import qs_pkg::*;

    qs_rcv_state_t r_state;
    qs_rcv_state_t w_state;
    logic [LW-1:0] r_len;
    logic [LW-1:0] w_len;
    logic [W-1:0]  r_min;
    logic [W-1:0]  w_min;
    logic [W-1:0]  r_last;
    logic [W-1:0]  w_last;
    logic          r_ord;
    logic          w_ord;
    logic          r_frm;
    logic          w_frm;
    logic          r_eng;
    logic          w_eng;
    logic          r_hold_vld;
    qs_rcv_stat_t  r_hold;
    logic          r_stray;
    logic          r_ovf;
    logic          w_done;
    logic          w_hold_ld;
    logic          w_stray;
    qs_rcv_stat_t  w_rec;
    qs_rcv_stat_t  w_fresh;
    logic          w_push;
    qs_rcv_stat_t  w_din;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_ovf;
    qs_rcv_stat_t  w_head;

    // Record for a packet that both starts and ends on the current beat.
    assign w_fresh = '{len: LW'(1), min: in_dat, max: in_dat, ord: 1'b0, frm: 1'b0, eng: in_err};

    always_comb begin
        w_state   = r_state;
        w_len     = r_len;
        w_min     = r_min;
        w_last    = r_last;
        w_ord     = r_ord;
        w_frm     = r_frm;
        w_eng     = r_eng;
        w_done    = 1'b0;
        w_hold_ld = 1'b0;
        w_stray   = 1'b0;
        // Default record closes the open packet as restarted (frm forced).
        w_rec     = '{len: r_len, min: r_min, max: r_last, ord: r_ord, frm: 1'b1, eng: r_eng};
        if (in_vld && in_sop) begin
            w_len     = LW'(1);
            w_min     = in_dat;
            w_last    = in_dat;
            w_ord     = 1'b0;
            w_frm     = 1'b0;
            w_eng     = in_err;
            w_state   = in_eop ? IDLE : PKT;
            w_done    = (r_state == PKT) || in_eop;
            // Restart plus single-beat packet: the second record waits one cycle.
            w_hold_ld = (r_state == PKT) && in_eop;
            if (r_state == IDLE) w_rec = w_fresh;
        end else if (in_vld && r_state == PKT) begin
            w_len   = (r_len > LW'(N)) ? r_len : r_len + LW'(1);
            w_ord   = r_ord | (in_dat < r_last);
            w_frm   = r_frm | (w_len > LW'(N));
            w_eng   = r_eng | in_err;
            w_last  = in_dat;
            w_state = in_eop ? IDLE : PKT;
            w_done  = in_eop;
            w_rec   = '{len: w_len, min: r_min, max: in_dat, ord: w_ord, frm: w_frm, eng: w_eng};
        end else begin
            w_stray = in_vld;
        end
    end

    // The held record always goes first; a completion colliding with it is lost.
    assign w_push = r_hold_vld | w_done;
    assign w_din  = r_hold_vld ? r_hold : w_rec;
    assign w_pop  = !w_empty && stat_rdy;
    assign w_ovf  = (w_push && w_full && !w_pop) || (r_hold_vld && w_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_min      <= '0;
            r_last     <= '0;
            r_ord      <= 1'b0;
            r_frm      <= 1'b0;
            r_eng      <= 1'b0;
            r_hold_vld <= 1'b0;
            r_hold     <= '0;
            r_stray    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_len      <= w_len;
            r_min      <= w_min;
            r_last     <= w_last;
            r_ord      <= w_ord;
            r_frm      <= w_frm;
            r_eng      <= w_eng;
            r_hold_vld <= w_hold_ld;
            if (w_hold_ld) r_hold <= w_fresh;
            r_stray    <= w_stray;
            r_ovf      <= r_ovf | w_ovf;
        end
    end

    qs_rcv_fifo #(.DEPTH(STAT_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign stat_vld_r     = !w_empty;
    assign stat_len_r     = w_head.len;
    assign stat_min_r     = w_head.min;
    assign stat_max_r     = w_head.max;
    assign stat_ord_err_r = w_head.ord;
    assign stat_frm_err_r = w_head.frm;
    assign stat_eng_err_r = w_head.eng;
    assign stray_r        = r_stray;
    assign ovf_r          = r_ovf;
    assign busy_r         = (r_state == PKT);
endmodule

// File: tb/tb_qs_rcv.sv
// tb_qs_rcv: directed and randomized check of qs_rcv against a packet-level reference model
module tb_qs_rcv;
    localparam int W     = qs_pkg::W;
    localparam int N     = qs_pkg::N;
    localparam int LW    = $clog2(N + 2);
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [LW-1:0] len;
        logic [W-1:0]  mn;
        logic [W-1:0]  mx;
        logic          ord;
        logic          frm;
        logic          eng;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld;
    logic          in_sop;
    logic          in_eop;
    logic          in_err;
    logic [W-1:0]  in_dat;
    logic          stat_rdy;
    logic          stat_vld_r;
    logic [LW-1:0] stat_len_r;
    logic [W-1:0]  stat_min_r;
    logic [W-1:0]  stat_max_r;
    logic          stat_ord_err_r;
    logic          stat_frm_err_r;
    logic          stat_eng_err_r;
    logic          stray_r;
    logic          ovf_r;
    logic          busy_r;

    int n_checks = 0;
    int n_fail   = 0;

    qs_rcv #(.STAT_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_vld         (in_vld),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_err         (in_err),
        .in_dat         (in_dat),
        .stat_rdy       (stat_rdy),
        .stat_vld_r     (stat_vld_r),
        .stat_len_r     (stat_len_r),
        .stat_min_r     (stat_min_r),
        .stat_max_r     (stat_max_r),
        .stat_ord_err_r (stat_ord_err_r),
        .stat_frm_err_r (stat_frm_err_r),
        .stat_eng_err_r (stat_eng_err_r),
        .stray_r        (stray_r),
        .ovf_r          (ovf_r),
        .busy_r         (busy_r)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: whole packets as beat lists, records derived from the list.
    logic [W-1:0] m_beats[$];
    logic         m_errs[$];
    rec_t         m_fifo[$];
    rec_t         m_hold;
    bit           m_hold_vld;
    bit           m_stray;
    bit           m_ovf;

    function automatic rec_t make_rec(bit frm_f);
        rec_t r;
        int   n = m_beats.size();
        r.len = (n > N) ? LW'(N + 1) : LW'(n);
        r.mn  = m_beats[0];
        r.mx  = m_beats[n-1];
        r.ord = 1'b0;
        r.eng = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && m_beats[i] < m_beats[i-1]) r.ord = 1'b1;
            if (m_errs[i]) r.eng = 1'b1;
        end
        r.frm = frm_f || (n > N);
        return r;
    endfunction

    task automatic fifo_put(rec_t r);
        if (m_fifo.size() < DEPTH) m_fifo.push_back(r);
        else m_ovf = 1'b1;
    endtask

    task automatic model_step();
        rec_t done[$];
        bit   pop = (m_fifo.size() != 0) && stat_rdy;
        m_stray = 1'b0;
        if (in_vld) begin
            if (in_sop) begin
                if (m_beats.size() != 0) done.push_back(make_rec(1'b1));
                m_beats.delete();
                m_errs.delete();
                m_beats.push_back(in_dat);
                m_errs.push_back(in_err);
                if (in_eop) begin
                    done.push_back(make_rec(1'b0));
                    m_beats.delete();
                    m_errs.delete();
                end
            end else if (m_beats.size() != 0) begin
                m_beats.push_back(in_dat);
                m_errs.push_back(in_err);
                if (in_eop) begin
                    done.push_back(make_rec(1'b0));
                    m_beats.delete();
                    m_errs.delete();
                end
            end else begin
                m_stray = 1'b1;
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (m_hold_vld) begin
            fifo_put(m_hold);
            m_hold_vld = 1'b0;
            if (done.size() != 0) m_ovf = 1'b1;
        end else if (done.size() != 0) begin
            fifo_put(done[0]);
            if (done.size() > 1) begin
                m_hold     = done[1];
                m_hold_vld = 1'b1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_beats.delete();
            m_errs.delete();
            m_fifo.delete();
            m_hold_vld = 1'b0;
            m_stray    = 1'b0;
            m_ovf      = 1'b0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        chk("vld", 32'(stat_vld_r), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            chk("len", 32'(stat_len_r), 32'(m_fifo[0].len));
            chk("min", 32'(stat_min_r), 32'(m_fifo[0].mn));
            chk("max", 32'(stat_max_r), 32'(m_fifo[0].mx));
            chk("ord", 32'(stat_ord_err_r), 32'(m_fifo[0].ord));
            chk("frm", 32'(stat_frm_err_r), 32'(m_fifo[0].frm));
            chk("eng", 32'(stat_eng_err_r), 32'(m_fifo[0].eng));
        end
        chk("stray", 32'(stray_r), 32'(m_stray));
        chk("ovf", 32'(ovf_r), 32'(m_ovf));
        chk("busy", 32'(busy_r), 32'(m_beats.size() != 0));
    end

    task automatic beat(bit s, bit e, bit er, int d);
        in_vld = 1'b1;
        in_sop = s;
        in_eop = e;
        in_err = er;
        in_dat = W'(d);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
        in_err = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_head(string nm, int len, int mn, int mx, bit o, bit f, bit e);
        chk({nm, "_vld"}, 32'(stat_vld_r), 1);
        chk({nm, "_len"}, 32'(stat_len_r), len);
        chk({nm, "_min"}, 32'(stat_min_r), mn);
        chk({nm, "_max"}, 32'(stat_max_r), mx);
        chk({nm, "_ord"}, 32'(stat_ord_err_r), 32'(o));
        chk({nm, "_frm"}, 32'(stat_frm_err_r), 32'(f));
        chk({nm, "_eng"}, 32'(stat_eng_err_r), 32'(e));
    endtask

    initial begin
        rst      = 1'b1;
        in_vld   = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_err   = 1'b0;
        in_dat   = '0;
        stat_rdy = 1'b1;
        idle(2);
        chk("rst_vld", 32'(stat_vld_r), 0);
        chk("rst_len", 32'(stat_len_r), 0);
        chk("rst_ovf", 32'(ovf_r), 0);
        chk("rst_busy", 32'(busy_r), 0);
        rst = 1'b0;
        idle(1);

        beat(1, 0, 0, 3); beat(0, 0, 0, 5); beat(0, 0, 0, 5); beat(0, 1, 0, 9);
        chk_head("t1", 4, 3, 9, 0, 0, 0);
        idle(2);

        beat(1, 0, 0, 7); beat(0, 0, 0, 2); beat(0, 1, 0, 8);
        chk_head("t2", 3, 7, 8, 1, 0, 0);
        idle(2);

        beat(1, 1, 0, 'h1F);
        chk_head("t3", 1, 'h1F, 'h1F, 0, 0, 0);
        beat(0, 0, 0, 'h22);
        chk("t3_stray", 32'(stray_r), 1);
        chk("t3_norec", 32'(stat_vld_r), 0);
        idle(1);
        chk("t3_stray_end", 32'(stray_r), 0);
        idle(1);

        beat(1, 0, 0, 4); beat(0, 0, 0, 6); beat(1, 1, 0, 1);
        chk_head("t4a", 2, 4, 6, 0, 1, 0);
        idle(1);
        chk_head("t4b", 1, 1, 1, 0, 0, 0);
        idle(2);

        stat_rdy = 1'b0;
        for (int i = 0; i < 5; i++) beat(1, 1, 0, 10 + i);
        chk("t5_ovf", 32'(ovf_r), 1);
        stat_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_vld", 32'(stat_vld_r), 1);
            chk("t5_order", 32'(stat_min_r), 10 + i);
            idle(1);
        end
        chk("t5_drained", 32'(stat_vld_r), 0);

        for (int i = 0; i < N + 2; i++) beat(i == 0, i == N + 1, i == 1, 2 * i);
        chk_head("t6", N + 1, 0, 2 * (N + 1), 0, 1, 1);
        idle(2);

        beat(1, 0, 0, 5); beat(0, 0, 0, 6);
        chk("t7_busy", 32'(busy_r), 1);
        rst = 1'b1;
        #1;
        chk("t7_busy0", 32'(busy_r), 0);
        chk("t7_vld0", 32'(stat_vld_r), 0);
        chk("t7_ovf0", 32'(ovf_r), 0);
        chk("t7_stray0", 32'(stray_r), 0);
        chk("t7_len0", 32'(stat_len_r), 0);
        chk("t7_max0", 32'(stat_max_r), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        for (int c = 0; c < 3000; c++) begin
            int ph = (c / 250) % 4;
            in_vld   = ($urandom_range(0, 9) < 7);
            in_sop   = ($urandom_range(0, 5) == 0);
            in_eop   = ($urandom_range(0, 5) == 0);
            in_err   = ($urandom_range(0, 19) == 0);
            in_dat   = ($urandom_range(0, 3) == 0) ? W'($urandom) : in_dat + W'($urandom_range(0, 8));
            stat_rdy = (ph == 0) ? 1'b0 : ($urandom_range(0, ph) != 0);
            rst      = (c == 1700);
            @(posedge clk);
            #1;
        end
        rst    = 1'b0;
        in_vld = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
